sync_fifo_ctrl: RTL and testbench

SYNC_FIFO_CTRL -- requirements
Module: sync_fifo_ctrl

---
 rtl/sync_fifo_ctrl_pkg.sv | 13 +
 rtl/sync_fifo_ctrl_if.sv | 37 +++
 rtl/fifo_ram_2p.sv | 30 +++
 rtl/sync_fifo_ctrl.sv | 152 +++++++++++++++
 tb/tb_sync_fifo_ctrl.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/sync_fifo_ctrl_pkg.sv
// Shared constants for the synchronous FIFO controller slice.
// Holds the default data/address widths and the occupancy-count width helper.
package sync_fifo_ctrl_pkg;

    localparam int unsigned NB_DATA_DEF = 72;
    localparam int unsigned NB_ADDR_DEF = 5;

    // Occupancy needs one extra bit so that 0..DEPTH is representable.
    function automatic int unsigned count_width(input int unsigned nb_addr);
        return nb_addr + 1;
    endfunction

endpackage

// File: rtl/sync_fifo_ctrl_if.sv
// Handshake/data bundle between a FIFO user and sync_fifo_ctrl.
// master : drives i_write_enb, i_read_enb, i_flush, i_data; observes data and status.
// slave  : the FIFO side, the mirror image of master.
interface sync_fifo_ctrl_if
    import sync_fifo_ctrl_pkg::*;
#(
    parameter int unsigned NB_DATA = NB_DATA_DEF,
    parameter int unsigned NB_ADDR = NB_ADDR_DEF
);

    logic                             i_write_enb;
    logic                             i_read_enb;
    logic                             i_flush;
    logic [NB_DATA-1:0]               i_data;
    logic [NB_DATA-1:0]               o_data;
    logic                             o_valid;
    logic                             o_full;
    logic                             o_empty;
    logic                             o_almost_full;
    logic                             o_almost_empty;
    logic [count_width(NB_ADDR)-1:0]  o_count;
    logic                             o_overflow;
    logic                             o_underflow;

    modport master (
        output i_write_enb, i_read_enb, i_flush, i_data,
        input  o_data, o_valid, o_full, o_empty, o_almost_full, o_almost_empty,
               o_count, o_overflow, o_underflow
    );

    modport slave (
        input  i_write_enb, i_read_enb, i_flush, i_data,
        output o_data, o_valid, o_full, o_empty, o_almost_full, o_almost_empty,
               o_count, o_overflow, o_underflow
    );

endinterface

// File: rtl/fifo_ram_2p.sv
// Two-port storage array: one synchronous write port, one asynchronous read port.
// Ports: i_clock, i_wr_en, i_wr_addr, i_wr_data, i_rd_addr, o_rd_data.
// Contents are deliberately not reset.
module fifo_ram_2p #(
    parameter int unsigned NB_DATA = 72,
    parameter int unsigned NB_ADDR = 5
) (
    input  logic               i_clock,
    input  logic               i_wr_en,
    input  logic [NB_ADDR-1:0] i_wr_addr,
    input  logic [NB_DATA-1:0] i_wr_data,
    input  logic [NB_ADDR-1:0] i_rd_addr,
    output logic [NB_DATA-1:0] o_rd_data
);

    localparam int unsigned DEPTH = 2 ** NB_ADDR;

    logic [NB_DATA-1:0] mem [DEPTH];

    // Write port
    always_ff @(posedge i_clock) begin
        if (i_wr_en) begin
            mem[i_wr_addr] <= i_wr_data;
        end
    end

    // Asynchronous read port
    assign o_rd_data = mem[i_rd_addr];

endmodule

// File: rtl/sync_fifo_ctrl.sv
// Synchronous FIFO controller: pointers, occupancy, status/sticky error flags, output stage.
// Ports: i_clock, i_reset (async, active-low), bus (sync_fifo_ctrl_if.slave) carrying
//        write/read/flush requests, write data, read data/valid, count and flags.
// Build option: define SYNC_FIFO_REG_OUT_EN for a registered read port (1-cycle latency,
//        o_valid pulses per read); otherwise show-ahead (o_data is the head word, o_valid = !empty).
module sync_fifo_ctrl
    import sync_fifo_ctrl_pkg::*;
#(
    parameter int unsigned NB_DATA   = NB_DATA_DEF,
    parameter int unsigned NB_ADDR   = NB_ADDR_DEF,
    parameter int unsigned AF_THRESH = (2 ** NB_ADDR) - 4,
    parameter int unsigned AE_THRESH = 4
) (
    input  logic           i_clock,
    input  logic           i_reset,
    sync_fifo_ctrl_if.slave bus
);

    localparam int unsigned NB_CNT = count_width(NB_ADDR);

    logic [NB_CNT-1:0]  wr_ptr;
    logic [NB_CNT-1:0]  rd_ptr;
    logic [NB_CNT-1:0]  wr_ptr_nxt;
    logic [NB_CNT-1:0]  rd_ptr_nxt;
    logic [NB_CNT-1:0]  count_q;
    logic [NB_CNT-1:0]  count_nxt;
    logic               full_q;
    logic               empty_q;
    logic               almost_full_q;
    logic               almost_empty_q;
    logic               overflow_q;
    logic               underflow_q;
    logic               full_nxt;
    logic               empty_nxt;
    logic               almost_full_nxt;
    logic               almost_empty_nxt;
    logic               overflow_nxt;
    logic               underflow_nxt;
    logic               wr_accept;
    logic               rd_accept;
    logic               wr_reject;
    logic               rd_reject;
    logic [NB_DATA-1:0] ram_rdata;

    // Accept/reject decisions and next-state of pointers and flags
    always_comb begin
        rd_accept        = 1'b0;
        wr_accept        = 1'b0;
        wr_reject        = 1'b0;
        rd_reject        = 1'b0;
        wr_ptr_nxt       = wr_ptr;
        rd_ptr_nxt       = rd_ptr;
        overflow_nxt     = overflow_q;
        underflow_nxt    = underflow_q;

        if (bus.i_flush) begin
            // Flush wins over any request in the same cycle
            wr_ptr_nxt    = '0;
            rd_ptr_nxt    = '0;
            overflow_nxt  = 1'b0;
            underflow_nxt = 1'b0;
        end else begin
            rd_accept = bus.i_read_enb && !empty_q;
            // A read in the same cycle frees a slot, so a full FIFO still takes the write
            wr_accept = bus.i_write_enb && (!full_q || rd_accept);
            wr_reject = bus.i_write_enb && !wr_accept;
            rd_reject = bus.i_read_enb && !rd_accept;
            wr_ptr_nxt    = wr_ptr + NB_CNT'(wr_accept);
            rd_ptr_nxt    = rd_ptr + NB_CNT'(rd_accept);
            overflow_nxt  = overflow_q | wr_reject;
            underflow_nxt = underflow_q | rd_reject;
        end

        count_nxt        = wr_ptr_nxt - rd_ptr_nxt;
        empty_nxt        = (wr_ptr_nxt == rd_ptr_nxt);
        full_nxt         = (wr_ptr_nxt[NB_CNT-1] != rd_ptr_nxt[NB_CNT-1]) &&
                           (wr_ptr_nxt[NB_ADDR-1:0] == rd_ptr_nxt[NB_ADDR-1:0]);
        almost_full_nxt  = (count_nxt >= NB_CNT'(AF_THRESH));
        almost_empty_nxt = (count_nxt <= NB_CNT'(AE_THRESH));
    end

    // Pointer and status registers
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            count_q        <= '0;
            full_q         <= 1'b0;
            empty_q        <= 1'b1;
            almost_full_q  <= 1'b0;
            almost_empty_q <= 1'b1;
            overflow_q     <= 1'b0;
            underflow_q    <= 1'b0;
        end else begin
            wr_ptr         <= wr_ptr_nxt;
            rd_ptr         <= rd_ptr_nxt;
            count_q        <= count_nxt;
            full_q         <= full_nxt;
            empty_q        <= empty_nxt;
            almost_full_q  <= almost_full_nxt;
            almost_empty_q <= almost_empty_nxt;
            overflow_q     <= overflow_nxt;
            underflow_q    <= underflow_nxt;
        end
    end

    fifo_ram_2p #(
        .NB_DATA (NB_DATA),
        .NB_ADDR (NB_ADDR)
    ) u_ram (
        .i_clock   (i_clock),
        .i_wr_en   (wr_accept),
        .i_wr_addr (wr_ptr[NB_ADDR-1:0]),
        .i_wr_data (bus.i_data),
        .i_rd_addr (rd_ptr[NB_ADDR-1:0]),
        .o_rd_data (ram_rdata)
    );

`ifdef SYNC_FIFO_REG_OUT_EN
    logic [NB_DATA-1:0] data_q;
    logic               valid_q;

    // Registered read port: capture the head word on each accepted read
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= rd_accept;
            if (rd_accept) begin
                data_q <= ram_rdata;
            end
        end
    end

    assign bus.o_data  = data_q;
    assign bus.o_valid = valid_q;
`else
    // Show-ahead: the head word is always presented
    assign bus.o_data  = ram_rdata;
    assign bus.o_valid = !empty_q;
`endif

    assign bus.o_count        = count_q;
    assign bus.o_full         = full_q;
    assign bus.o_empty        = empty_q;
    assign bus.o_almost_full  = almost_full_q;
    assign bus.o_almost_empty = almost_empty_q;
    assign bus.o_overflow     = overflow_q;
    assign bus.o_underflow    = underflow_q;

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Directed self-checking bench for sync_fifo_ctrl (default parameters, both output modes).
module tb_sync_fifo_ctrl;

    localparam int unsigned NB_DATA = 72;
    localparam int unsigned NB_ADDR = 5;

    logic i_clock;
    logic i_reset;
    int   tests_run;
    int   tests_failed;

    sync_fifo_ctrl_if #(.NB_DATA(NB_DATA), .NB_ADDR(NB_ADDR)) bus ();

    sync_fifo_ctrl #(
        .NB_DATA   (NB_DATA),
        .NB_ADDR   (NB_ADDR),
        .AF_THRESH (28),
        .AE_THRESH (4)
    ) u_dut (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .bus     (bus)
    );

    initial begin
        i_clock = 1'b0;
        forever #5 i_clock = ~i_clock;
    end

    task automatic check_eq(input string tag, input logic [NB_DATA-1:0] act,
                            input logic [NB_DATA-1:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge i_clock);
        #1;
    endtask

    // Pop one word and check it in whichever output mode is built
    task automatic pop_check(input string tag, input logic [NB_DATA-1:0] exp);
        bus.i_write_enb = 1'b0;
        bus.i_read_enb  = 1'b1;
`ifndef SYNC_FIFO_REG_OUT_EN
        check_eq(tag, bus.o_data, exp);
`endif
        step();
`ifdef SYNC_FIFO_REG_OUT_EN
        check_eq(tag, bus.o_data, exp);
        check_eq({tag, "_valid"}, NB_DATA'(bus.o_valid), NB_DATA'(1));
`endif
        bus.i_read_enb = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        check_eq({tag, "_count"}, NB_DATA'(bus.o_count), NB_DATA'(0));
        check_eq({tag, "_empty"}, NB_DATA'(bus.o_empty), NB_DATA'(1));
        check_eq({tag, "_aempty"}, NB_DATA'(bus.o_almost_empty), NB_DATA'(1));
        check_eq({tag, "_full"}, NB_DATA'(bus.o_full), NB_DATA'(0));
        check_eq({tag, "_afull"}, NB_DATA'(bus.o_almost_full), NB_DATA'(0));
        check_eq({tag, "_ovf"}, NB_DATA'(bus.o_overflow), NB_DATA'(0));
        check_eq({tag, "_udf"}, NB_DATA'(bus.o_underflow), NB_DATA'(0));
`ifdef SYNC_FIFO_REG_OUT_EN
        check_eq({tag, "_valid"}, NB_DATA'(bus.o_valid), NB_DATA'(0));
        check_eq({tag, "_data"}, bus.o_data, NB_DATA'(0));
`endif
    endtask

    initial begin
        tests_run       = 0;
        tests_failed    = 0;
        bus.i_write_enb = 1'b0;
        bus.i_read_enb  = 1'b0;
        bus.i_flush     = 1'b0;
        bus.i_data      = '0;
        i_reset         = 1'b1;
        #1 i_reset = 1'b0;
        #1;
        check_reset_state("reset");
        repeat (2) @(negedge i_clock);
        i_reset = 1'b1;

        // Fill with 0..31
        for (int i = 0; i < 32; i++) begin
            bus.i_write_enb = 1'b1;
            bus.i_data      = NB_DATA'(i);
            step();
            check_eq($sformatf("fill%0d_count", i), NB_DATA'(bus.o_count), NB_DATA'(i + 1));
            check_eq($sformatf("fill%0d_afull", i), NB_DATA'(bus.o_almost_full),
                     NB_DATA'((i + 1) >= 28));
            check_eq($sformatf("fill%0d_aempty", i), NB_DATA'(bus.o_almost_empty),
                     NB_DATA'((i + 1) <= 4));
            check_eq($sformatf("fill%0d_full", i), NB_DATA'(bus.o_full), NB_DATA'(i == 31));
        end
        check_eq("fill_ovf", NB_DATA'(bus.o_overflow), NB_DATA'(0));

        // Write into full FIFO without read: dropped, overflow sticks
        bus.i_data = NB_DATA'(8'h99);
        step();
        check_eq("ovf_count", NB_DATA'(bus.o_count), NB_DATA'(32));
        check_eq("ovf_set", NB_DATA'(bus.o_overflow), NB_DATA'(1));
        bus.i_write_enb = 1'b0;
        step();
        check_eq("ovf_hold", NB_DATA'(bus.o_overflow), NB_DATA'(1));

        // Full FIFO, write 0xAA with simultaneous read
        bus.i_write_enb = 1'b1;
        bus.i_data      = NB_DATA'(8'hAA);
        bus.i_read_enb  = 1'b1;
`ifndef SYNC_FIFO_REG_OUT_EN
        check_eq("fullrw_data", bus.o_data, NB_DATA'(0));
`endif
        step();
`ifdef SYNC_FIFO_REG_OUT_EN
        check_eq("fullrw_data", bus.o_data, NB_DATA'(0));
        check_eq("fullrw_valid", NB_DATA'(bus.o_valid), NB_DATA'(1));
`endif
        bus.i_write_enb = 1'b0;
        bus.i_read_enb  = 1'b0;
        check_eq("fullrw_count", NB_DATA'(bus.o_count), NB_DATA'(32));
        check_eq("fullrw_full", NB_DATA'(bus.o_full), NB_DATA'(1));
        check_eq("fullrw_ovf", NB_DATA'(bus.o_overflow), NB_DATA'(1));

        // Drain: 1..31 then 0xAA
        for (int k = 0; k < 32; k++) begin
            pop_check($sformatf("drain%0d", k), (k < 31) ? NB_DATA'(k + 1) : NB_DATA'(8'hAA));
        end
        check_eq("drain_count", NB_DATA'(bus.o_count), NB_DATA'(0));
        check_eq("drain_empty", NB_DATA'(bus.o_empty), NB_DATA'(1));
        check_eq("drain_udf", NB_DATA'(bus.o_underflow), NB_DATA'(0));

        // Empty FIFO, simultaneous write 0x55 and read
        bus.i_write_enb = 1'b1;
        bus.i_read_enb  = 1'b1;
        bus.i_data      = NB_DATA'(8'h55);
        step();
        bus.i_write_enb = 1'b0;
        bus.i_read_enb  = 1'b0;
        check_eq("emptyrw_count", NB_DATA'(bus.o_count), NB_DATA'(1));
        check_eq("emptyrw_udf", NB_DATA'(bus.o_underflow), NB_DATA'(1));
`ifdef SYNC_FIFO_REG_OUT_EN
        check_eq("emptyrw_valid", NB_DATA'(bus.o_valid), NB_DATA'(0));
`endif
        pop_check("emptyrw_read", NB_DATA'(8'h55));
        check_eq("emptyrw_after", NB_DATA'(bus.o_count), NB_DATA'(0));

        // Flush clears sticky flags
        bus.i_flush = 1'b1;
        step();
        bus.i_flush = 1'b0;
        check_eq("flush_ovf", NB_DATA'(bus.o_overflow), NB_DATA'(0));
        check_eq("flush_udf", NB_DATA'(bus.o_underflow), NB_DATA'(0));
        check_eq("flush_count", NB_DATA'(bus.o_count), NB_DATA'(0));

        // Streaming 100 words across several pointer wraps
        bus.i_write_enb = 1'b1;
        bus.i_data      = NB_DATA'(16'h100);
        step();
        check_eq("stream_prime", NB_DATA'(bus.o_count), NB_DATA'(1));
        for (int i = 1; i < 100; i++) begin
            bus.i_write_enb = 1'b1;
            bus.i_read_enb  = 1'b1;
            bus.i_data      = NB_DATA'(16'h100 + i);
`ifndef SYNC_FIFO_REG_OUT_EN
            check_eq($sformatf("stream%0d_data", i), bus.o_data, NB_DATA'(16'h100 + i - 1));
`endif
            step();
`ifdef SYNC_FIFO_REG_OUT_EN
            check_eq($sformatf("stream%0d_data", i), bus.o_data, NB_DATA'(16'h100 + i - 1));
`endif
            check_eq($sformatf("stream%0d_count", i), NB_DATA'(bus.o_count), NB_DATA'(1));
        end
        pop_check("stream_last", NB_DATA'(16'h100 + 99));
        check_eq("stream_end_count", NB_DATA'(bus.o_count), NB_DATA'(0));
        check_eq("stream_udf", NB_DATA'(bus.o_underflow), NB_DATA'(0));

        // Fill to 10, then assert reset between edges
        for (int i = 0; i < 10; i++) begin
            bus.i_write_enb = 1'b1;
            bus.i_data      = NB_DATA'(16'h200 + i);
            step();
        end
        bus.i_write_enb = 1'b0;
        check_eq("pre_rst_count", NB_DATA'(bus.o_count), NB_DATA'(10));
        check_eq("pre_rst_aempty", NB_DATA'(bus.o_almost_empty), NB_DATA'(0));
        #2 i_reset = 1'b0;
        #1;
        check_reset_state("midrst");
        @(negedge i_clock);
        i_reset = 1'b1;
        step();
        check_eq("postrst_count", NB_DATA'(bus.o_count), NB_DATA'(0));
        check_eq("postrst_empty", NB_DATA'(bus.o_empty), NB_DATA'(1));

        // Flush while writing
        for (int i = 0; i < 3; i++) begin
            bus.i_write_enb = 1'b1;
            bus.i_data      = NB_DATA'(16'h300 + i);
            step();
        end
        check_eq("preflush_count", NB_DATA'(bus.o_count), NB_DATA'(3));
        bus.i_flush = 1'b1;
        step();
        check_eq("flushwr_count", NB_DATA'(bus.o_count), NB_DATA'(0));
        check_eq("flushwr_empty", NB_DATA'(bus.o_empty), NB_DATA'(1));
        bus.i_flush     = 1'b0;
        bus.i_write_enb = 1'b0;
        step();
        check_eq("flushwr_hold", NB_DATA'(bus.o_count), NB_DATA'(0));

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
